// File: rtl/controller_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : controller_sequencer_if
// Description : Opcode-in / T-state and control-word-out bundle for the
//               controller_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface controller_sequencer_if;
    logic [3:0]  opcode;
    logic [5:0]  tstate;
    logic [11:0] con;
    logic        hlt;

    modport master (output opcode, input tstate, input con, input hlt);
    modport slave  (input opcode, output tstate, output con, output hlt);
endinterface
`default_nettype wire

// File: rtl/controller_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : controller_sequencer
// Description : Six-phase one-hot T-state ring with a combinational control
//               word decoder and HLT latch. With VARIABLE_CYCLE_EN defined,
//               LDA/OUT/NOP return to T1 early.
// Revision    : 1.0 - initial release
// ============================================================================
module controller_sequencer (
    input  wire logic              clk,
    input  wire logic              rst,
    controller_sequencer_if.slave  sq
);
    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_t;

    localparam logic [3:0] c_OP_LDA = 4'b0000;
    localparam logic [3:0] c_OP_ADD = 4'b0001;
    localparam logic [3:0] c_OP_SUB = 4'b0010;
    localparam logic [3:0] c_OP_OUT = 4'b1110;
    localparam logic [3:0] c_OP_HLT = 4'b1111;

    // Control word bit positions: {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}
    localparam logic [11:0] c_CP = 12'h800;
    localparam logic [11:0] c_EP = 12'h400;
    localparam logic [11:0] c_LM = 12'h200;
    localparam logic [11:0] c_CE = 12'h100;
    localparam logic [11:0] c_LI = 12'h080;
    localparam logic [11:0] c_EI = 12'h040;
    localparam logic [11:0] c_LA = 12'h020;
    localparam logic [11:0] c_EA = 12'h010;
    localparam logic [11:0] c_SU = 12'h008;
    localparam logic [11:0] c_EU = 12'h004;
    localparam logic [11:0] c_LB = 12'h002;
    localparam logic [11:0] c_LO = 12'h001;

    tstate_t     r_tstate;
    logic        r_hlt;
    tstate_t     w_next;
    logic [11:0] w_con;
    logic        w_is_nop;

    assign w_is_nop = (sq.opcode != c_OP_LDA) && (sq.opcode != c_OP_ADD) &&
                      (sq.opcode != c_OP_SUB) && (sq.opcode != c_OP_OUT) &&
                      (sq.opcode != c_OP_HLT);

    always_comb begin
        w_next = T1;
        case (r_tstate)
            T1:      w_next = T2;
            T2:      w_next = T3;
`ifdef VARIABLE_CYCLE_EN
            T3:      w_next = w_is_nop ? T1 : T4;
            T4:      w_next = (sq.opcode == c_OP_OUT) ? T1 : T5;
            T5:      w_next = (sq.opcode == c_OP_LDA) ? T1 : T6;
`else
            T3:      w_next = T4;
            T4:      w_next = T5;
            T5:      w_next = T6;
`endif
            T6:      w_next = T1;
            default: w_next = T1;
        endcase
    end

    // Halt freezes the ring at T4; only rst releases it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tstate <= T1;
            r_hlt    <= 1'b0;
        end else if (!r_hlt) begin
            if ((r_tstate == T4) && (sq.opcode == c_OP_HLT)) begin
                r_hlt <= 1'b1;
            end else begin
                r_tstate <= w_next;
            end
        end
    end

    always_comb begin
        w_con = 12'h000;
        if (!rst && !r_hlt) begin
            case (r_tstate)
                T1: w_con = c_EP | c_LM;
                T2: w_con = c_CP;
                T3: w_con = c_CE | c_LI;
                T4: begin
                    if ((sq.opcode == c_OP_LDA) || (sq.opcode == c_OP_ADD) ||
                        (sq.opcode == c_OP_SUB))
                        w_con = c_EI | c_LM;
                    else if (sq.opcode == c_OP_OUT)
                        w_con = c_EA | c_LO;
                end
                T5: begin
                    if (sq.opcode == c_OP_LDA)
                        w_con = c_CE | c_LA;
                    else if ((sq.opcode == c_OP_ADD) || (sq.opcode == c_OP_SUB))
                        w_con = c_CE | c_LB;
                end
                T6: begin
                    if (sq.opcode == c_OP_ADD)
                        w_con = c_EU | c_LA;
                    else if (sq.opcode == c_OP_SUB)
                        w_con = c_EU | c_SU | c_LA;
                end
                default: w_con = 12'h000;
            endcase
        end
    end

    assign sq.tstate = r_tstate;
    assign sq.hlt    = r_hlt;
    assign sq.con    = w_con;
endmodule
`default_nettype wire
